// File: rtl/audio_slot_sched.sv
// Time-slot scheduler for the shared L/R sigma-delta DAC pair. A shadow slot
// table is written by the CPU and swapped into the active table at a wrap.
module audio_slot_sched #(
    parameter int SLOTS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_d,
    output logic [7:0] cfg_q,
    output logic [2:0] sel_l,
    output logic [2:0] sel_r,
    output logic [2:0] slot,
    output logic       pending
);

    localparam logic [2:0] LAST_IDX   = 3'(SLOTS - 1);
    localparam logic [3:0] SLOTS_ADDR = 4'(SLOTS);
    localparam logic [3:0] ADDR_COMMIT = 4'd8;
    localparam logic [3:0] ADDR_CTRL   = 4'd9;
    localparam logic [2:0] SRC_SILENCE = 3'd7;
    localparam logic [7:0] RESET_TABLE [8] = '{
        8'h40, 8'h59, 8'h59, 8'h52, 8'h74, 8'h74, 8'hED, 8'h3F
    };

    logic [7:0] active_q [8];
    logic [7:0] active_d [8];
    logic [7:0] shadow_q [8];
    logic [7:0] shadow_d [8];
    logic [7:0] ctrl_q, ctrl_d;
    logic [2:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [2:0] sel_l_q, sel_l_d;
    logic [2:0] sel_r_q, sel_r_d;
    logic [2:0] slot_q;

    logic       advance;
    logic       wrap;
    logic       swap;
    logic [7:0] cur_entry;
    logic [7:0] nxt_entry;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned (no latch); blocking '=' is correct in here only.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && cfg_addr < SLOTS_ADDR) begin
            shadow_d[cfg_addr[2:0]] = cfg_d;
        end

        ctrl_d = ctrl_q;
        if (cfg_we && cfg_addr == ADDR_CTRL) begin
            ctrl_d = cfg_d;
        end

        advance   = ce && !ctrl_q[1];
        cur_entry = active_q[idx_q];
        wrap      = cur_entry[7] || (idx_q == LAST_IDX);
        // Swap decision uses the pre-edge pending; the shadow copy includes
        // a write landing on the same edge.
        swap      = advance && wrap && pending_q;

        idx_d = idx_q;
        if (advance) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end

        active_d = swap ? shadow_d : active_q;

        pending_d = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end
        if (cfg_we && cfg_addr == ADDR_COMMIT) begin
            pending_d = cfg_d[0];
        end

        nxt_entry = active_d[idx_d];
        if (ctrl_q[0] || !nxt_entry[6]) begin
            sel_l_d = SRC_SILENCE;
            sel_r_d = SRC_SILENCE;
        end else begin
            sel_l_d = nxt_entry[2:0];
            sel_r_d = nxt_entry[5:3];
        end
    end

    // NOTE: both tables are reset to the default sequence; unlike plain RAM the
    // table must hold known contents out of reset, so it lives in flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q  <= RESET_TABLE;
            shadow_q  <= RESET_TABLE;
            ctrl_q    <= 8'h00;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            sel_l_q   <= 3'd0;
            sel_r_q   <= 3'd0;
            slot_q    <= 3'd0;
        end else begin
            // NOTE: non-blocking '<=' for all state so every flop samples
            // pre-edge values regardless of statement order.
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            ctrl_q    <= ctrl_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            sel_l_q   <= sel_l_d;
            sel_r_q   <= sel_r_d;
            slot_q    <= idx_d;
        end
    end

    always_comb begin
        cfg_q = 8'h00;
        if (!cfg_addr[3]) begin
            cfg_q = shadow_q[cfg_addr[2:0]];
        end else if (cfg_addr == ADDR_COMMIT) begin
            cfg_q = {7'd0, pending_q};
        end else if (cfg_addr == ADDR_CTRL) begin
            cfg_q = ctrl_q;
        end
    end

    assign sel_l   = sel_l_q;
    assign sel_r   = sel_r_q;
    assign slot    = slot_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_audio_slot_sched.sv
// Directed bench for audio_slot_sched: default sequence, commit/swap timing,
// same-edge interactions, mute/hold, disabled slots and asynchronous reset.
module tb_audio_slot_sched;

    logic       clock;
    logic       reset;
    logic       ce;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_d;
    logic [7:0] cfg_q;
    logic [2:0] sel_l;
    logic [2:0] sel_r;
    logic [2:0] slot;
    logic       pending;

    int n_tests = 0;
    int n_fail  = 0;

    audio_slot_sched #(.SLOTS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .cfg_we  (cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_d   (cfg_d),
        .cfg_q   (cfg_q),
        .sel_l   (sel_l),
        .sel_r   (sel_r),
        .slot    (slot),
        .pending (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int s, input int l, input int r);
        check({tag, ".slot"}, {5'd0, slot},  8'(s));
        check({tag, ".sel_l"}, {5'd0, sel_l}, 8'(l));
        check({tag, ".sel_r"}, {5'd0, sel_r}, 8'(r));
    endtask

    task automatic step(input logic c, input logic we, input logic [3:0] a, input logic [7:0] d);
        ce       = c;
        cfg_we   = we;
        cfg_addr = a;
        cfg_d    = d;
        @(posedge clock);
        #1;
        ce     = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic pulse();
        step(1'b1, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        check(tag, cfg_q, exp);
    endtask

    // Default-table outputs per slot, derived by hand from the reset entries.
    int def_l [7] = '{0, 1, 1, 2, 4, 4, 5};
    int def_r [7] = '{0, 3, 3, 2, 6, 6, 5};

    initial begin
        reset    = 1'b0;
        ce       = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 4'd0;
        cfg_d    = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        expect_out("reset", 0, 0, 0);
        check("reset.pending", {7'd0, pending}, 8'h00);
        rd("reset.sh0", 4'd0, 8'h40);
        rd("reset.sh6", 4'd6, 8'hED);
        rd("reset.sh7", 4'd7, 8'h3F);
        rd("reset.ctrl", 4'd9, 8'h00);
        reset = 1'b1;
        @(posedge clock);
        #1;
        expect_out("idle", 0, 0, 0);

        // Default 7-slot sequence, twice round.
        for (int k = 1; k <= 14; k++) begin
            pulse();
            expect_out($sformatf("seq%0d", k), k % 7, def_l[k % 7], def_r[k % 7]);
        end

        // Commit mid-sequence: old table runs out, swap at the wrap.
        repeat (3) pulse();
        expect_out("pre_commit", 3, 2, 2);
        wr(4'd0, 8'h40);
        wr(4'd1, 8'hC9);
        wr(4'd8, 8'h01);
        check("commit.pending", {7'd0, pending}, 8'h01);
        rd("commit.sh1", 4'd1, 8'hC9);
        rd("commit.rd8", 4'd8, 8'h01);
        pulse(); expect_out("old4", 4, 4, 6);
        pulse(); expect_out("old5", 5, 4, 6);
        pulse(); expect_out("old6", 6, 5, 5);
        check("old6.pending", {7'd0, pending}, 8'h01);
        pulse(); expect_out("swap0", 0, 0, 0);
        check("swap0.pending", {7'd0, pending}, 8'h00);
        pulse(); expect_out("new1", 1, 1, 1);
        pulse(); expect_out("new0", 0, 0, 0);
        pulse(); expect_out("new1b", 1, 1, 1);

        // Shadow[0] write on the swap edge is forwarded into the copy.
        wr(4'd8, 8'h01);
        step(1'b1, 1'b1, 4'd0, 8'h53);
        expect_out("fwd0", 0, 3, 2);
        check("fwd0.pending", {7'd0, pending}, 8'h00);
        pulse(); expect_out("fwd1", 1, 1, 1);
        pulse(); expect_out("fwd0b", 0, 3, 2);
        pulse(); expect_out("fwd1b", 1, 1, 1);

        // Commit on a wrap edge with pending=0: swap waits for the next wrap.
        wr(4'd1, 8'hD2);
        step(1'b1, 1'b1, 4'd8, 8'h01);
        expect_out("cwrap0", 0, 3, 2);
        check("cwrap0.pending", {7'd0, pending}, 8'h01);
        pulse(); expect_out("cwrap1", 1, 1, 1);
        pulse(); expect_out("cwrap_swap", 0, 3, 2);
        check("cwrap_swap.pending", {7'd0, pending}, 8'h00);
        pulse(); expect_out("cwrap_new1", 1, 2, 2);

        // Mute: silence on both channels, slot still advances.
        wr(4'd9, 8'h01);
        rd("mute.ctrl", 4'd9, 8'h01);
        pulse(); expect_out("mute0", 0, 7, 7);
        pulse(); expect_out("mute1", 1, 7, 7);
        wr(4'd9, 8'h00);
        pulse(); expect_out("unmute0", 0, 3, 2);

        // Hold: ce ignored, commit deferred until hold clears and a wrap occurs.
        wr(4'd1, 8'hC9);
        wr(4'd9, 8'h02);
        wr(4'd8, 8'h01);
        for (int k = 0; k < 3; k++) begin
            pulse();
            expect_out($sformatf("hold%0d", k), 0, 3, 2);
            check($sformatf("hold%0d.pending", k), {7'd0, pending}, 8'h01);
        end
        wr(4'd9, 8'hA8);
        rd("ctrl_spare", 4'd9, 8'hA8);
        pulse(); expect_out("unhold1", 1, 2, 2);
        check("unhold1.pending", {7'd0, pending}, 8'h01);
        pulse(); expect_out("unhold_swap", 0, 3, 2);
        check("unhold_swap.pending", {7'd0, pending}, 8'h00);
        pulse(); expect_out("unhold_new1", 1, 1, 1);

        // Disabled entry in slot 2 still takes one ce period.
        wr(4'd0, 8'h40);
        wr(4'd1, 8'h59);
        wr(4'd2, 8'h3F);
        wr(4'd3, 8'hD2);
        wr(4'd8, 8'h01);
        pulse(); expect_out("dis0", 0, 0, 0);
        pulse(); expect_out("dis1", 1, 1, 3);
        pulse(); expect_out("dis2", 2, 7, 7);
        pulse(); expect_out("dis3", 3, 2, 2);
        pulse(); expect_out("dis_wrap", 0, 0, 0);

        // Unmapped addresses read as zero and writes there have no effect.
        wr(4'd12, 8'hFF);
        rd("rd12", 4'd12, 8'h00);
        rd("rd10", 4'd10, 8'h00);
        rd("ctrl_kept", 4'd9, 8'hA8);
        check("ign.pending", {7'd0, pending}, 8'h00);

        // Asynchronous reset mid-sequence with a pending commit.
        pulse(); expect_out("pre_rst", 1, 1, 3);
        wr(4'd8, 8'h01);
        check("pre_rst.pending", {7'd0, pending}, 8'h01);
        #3;
        reset = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0);
        check("async_rst.pending", {7'd0, pending}, 8'h00);
        rd("async_rst.sh3", 4'd3, 8'h52);
        rd("async_rst.ctrl", 4'd9, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // No last flag anywhere: index runs to SLOTS-1 and wraps there.
        wr(4'd6, 8'h6D);
        wr(4'd8, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            pulse();
            expect_out($sformatf("pre7_%0d", k), k, def_l[k], def_r[k]);
        end
        pulse(); expect_out("swap7", 0, 0, 0);
        repeat (5) pulse();
        expect_out("full5", 5, 4, 6);
        pulse(); expect_out("full6", 6, 5, 5);
        pulse(); expect_out("full7", 7, 7, 7);
        pulse(); expect_out("full_wrap", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
